// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared RAM handshake and coherency-bus types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, IF, WB, SNOOP, C2C, M2C} busstate_t;
endpackage

// File: rtl/coherency_bus_ctrl_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping at N-1
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 valid
);
  localparam int IW = $clog2(N);
  // Scan farthest-first so the nearest set bit overwrites and wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % N)]) begin
        grant = IW'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/coherency_bus_ctrl.sv
// coherency_bus_ctrl: N-core snooping coherency controller and RAM arbiter
module coherency_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NCORES    = 2,
  parameter int BLK_WORDS = 2,
  parameter int SNOOP_MAX = 15
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic      [NCORES-1:0]   iREN,
  input  word_t     [NCORES-1:0]   iaddr,
  input  logic      [NCORES-1:0]   dREN,
  input  logic      [NCORES-1:0]   dWEN,
  input  word_t     [NCORES-1:0]   daddr,
  input  word_t     [NCORES-1:0]   dstore,
  input  logic      [NCORES-1:0]   ccwrite,
  output logic      [NCORES-1:0]   iwait,
  output logic      [NCORES-1:0]   dwait,
  output word_t     [NCORES-1:0]   iload,
  output word_t     [NCORES-1:0]   dload,
  output logic      [NCORES-1:0]   ccwait,
  output logic      [NCORES-1:0]   ccinv,
  output word_t     [NCORES-1:0]   ccsnoopaddr,
  input  ramstate_t                ramstate,
  input  word_t                    ramload,
  output word_t                    ramaddr,
  output word_t                    ramstore,
  output logic                     ramREN,
  output logic                     ramWEN
);
  localparam int IW = $clog2(NCORES);
  localparam int WW = $clog2(BLK_WORDS) + 1;
  localparam int SW = $clog2(SNOOP_MAX + 1);
  busstate_t state, nstate;
  logic [IW-1:0] gptr, req, rsp, req_inc, ngrant, sgrant;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] scnt;
  logic [NCORES-1:0] elig, peer, dirty;
  logic nvalid, svalid, acc, last, timeout, live, abort;
  assign elig    = iREN | dREN | dWEN;
  assign peer    = ~(NCORES'(1) << req);
  assign dirty   = dWEN & ccwrite & peer;
  assign req_inc = (req == IW'(NCORES - 1)) ? '0 : req + 1'b1;
  assign acc     = ramstate == ACCESS;
  assign last    = wcnt == WW'(BLK_WORDS - 1);
  assign timeout = scnt + 1'b1 == SW'(SNOOP_MAX);
  // The request bit that opened the transaction must stay up, or we abandon it.
  assign live    = (state == IF) ? iREN[req] : (state == WB) ? dWEN[req] : dREN[req];
  assign abort   = (state != IDLE) && !live;
  rr_arbiter #(.N(NCORES)) u_arb (.req(elig),  .ptr(gptr),    .grant(ngrant), .valid(nvalid));
  rr_arbiter #(.N(NCORES)) u_snp (.req(dirty), .ptr(req_inc), .grant(sgrant), .valid(svalid));
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (nvalid) nstate = dWEN[ngrant] ? WB : dREN[ngrant] ? SNOOP : IF;
      IF:      if (acc) nstate = IDLE;
      SNOOP:   nstate = svalid ? C2C : (!(|(dWEN & peer)) || timeout) ? M2C : SNOOP;
      default: if (acc && last) nstate = IDLE;
    endcase
    if (abort) nstate = IDLE;
  end
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    if (!abort) begin
      case (state)
        IF: begin
          ramREN     = 1'b1;
          ramaddr    = iaddr[req];
          iload[req] = ramload;
          iwait[req] = !acc;
        end
        WB: begin
          ramWEN     = 1'b1;
          ramaddr    = daddr[req];
          ramstore   = dstore[req];
          dwait[req] = !acc;
        end
        SNOOP: begin
          ccwait = peer;
          ccinv  = ccwrite[req] ? peer : '0;
          for (int k = 0; k < NCORES; k++) if (peer[k]) ccsnoopaddr[k] = daddr[req];
        end
        C2C: begin
          ccwait[rsp] = 1'b1;
          dload[req]  = dstore[rsp];
          ramWEN      = 1'b1;
          ramaddr     = daddr[rsp];
          ramstore    = dstore[rsp];
          dwait[req]  = !acc;
          dwait[rsp]  = !acc;
        end
        M2C: begin
          ramREN     = 1'b1;
          ramaddr    = daddr[req];
          dload[req] = ramload;
          dwait[req] = !acc;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      gptr  <= '0;
      req   <= '0;
      rsp   <= '0;
      wcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && nvalid) begin
        req  <= ngrant;
        wcnt <= '0;
        scnt <= '0;
      end
      if (state == SNOOP) begin
        scnt <= scnt + 1'b1;
        if (svalid) rsp <= sgrant;
      end
      if (acc && !abort && (state == WB || state == C2C || state == M2C)) wcnt <= wcnt + 1'b1;
      if (state != IDLE && nstate == IDLE) gptr <= req_inc;
    end
  end
endmodule

// File: tb/tb_coherency_bus_ctrl.sv
// tb_coherency_bus_ctrl: directed per-cycle vectors plus timeout and reset sequences
module tb_coherency_bus_ctrl;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic nRST;
  logic [3:0] iREN, dREN, dWEN, ccwrite, iwait, dwait, ccwait, ccinv;
  word_t [3:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  ramstate_t ramstate;
  word_t ramload, ramaddr, ramstore;
  logic ramREN, ramWEN;
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  coherency_bus_ctrl #(.NCORES(4), .BLK_WORDS(2), .SNOOP_MAX(15)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN)
  );
  typedef struct packed {
    logic [3:0] iren, dren, dwen, ccw;
    ramstate_t  rs;
    word_t      ld, a0;
    busstate_t  st;
    logic       ren, wen;
    word_t      addr, store;
    logic [3:0] iw, dw, cw, inv;
    logic [1:0] g;
    int         c;
    word_t      il, dl;
  } vec_t;
  vec_t tv[$];
  task automatic add(input vec_t x);
    tv.push_back(x);
  endtask
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    iREN = x.iren; dREN = x.dren; dWEN = x.dwen; ccwrite = x.ccw;
    ramstate = x.rs; ramload = x.ld; daddr[0] = x.a0;
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    // Arbitration: core 1 alone moves gptr to 2, then cores 1 and 3 compete.
    add('{4'b0010,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,0, 1,0,0});
    add('{4'b0010,0,0,0,ACCESS,32'h12345678,0, IF,1,0,32'h1004,0,4'b1101,4'hF,0,0,0, 1,32'h12345678,0});
    add('{4'b1010,0,0,0,BUSY,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,2, 3,0,0});
    add('{4'b1010,0,0,0,BUSY,0,0, IF,1,0,32'h100C,0,4'hF,4'hF,0,0,2, 3,0,0});
    add('{4'b1010,0,0,0,ERROR,32'h55,0, IF,1,0,32'h100C,0,4'hF,4'hF,0,0,2, 3,32'h55,0});
    add('{4'b1010,0,0,0,ACCESS,32'h3333,0, IF,1,0,32'h100C,0,4'b0111,4'hF,0,0,2, 3,32'h3333,0});
    add('{4'b0010,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,0, 1,0,0});
    add('{4'b0010,0,0,0,ACCESS,32'h4444,0, IF,1,0,32'h1004,0,4'b1101,4'hF,0,0,0, 1,32'h4444,0});
    add('{0,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,2, 1,0,0});
    // Two-word writeback by core 0.
    add('{0,0,4'b0001,0,FREE,0,32'h100, IDLE,0,0,0,0,4'hF,4'hF,0,0,2, 0,0,0});
    add('{0,0,4'b0001,0,BUSY,0,32'h100, WB,0,1,32'h100,32'hAAAA0000,4'hF,4'hF,0,0,2, 0,0,0});
    add('{0,0,4'b0001,0,ACCESS,0,32'h100, WB,0,1,32'h100,32'hAAAA0000,4'hF,4'b1110,0,0,2, 0,0,0});
    add('{0,0,4'b0001,0,ACCESS,0,32'h104, WB,0,1,32'h104,32'hAAAA0000,4'hF,4'b1110,0,0,2, 0,0,0});
    add('{0,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,1, 0,0,0});
    // Clean miss by core 1.
    add('{0,4'b0010,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,1, 1,0,0});
    add('{0,4'b0010,0,0,FREE,0,0, SNOOP,0,0,0,0,4'hF,4'hF,4'b1101,0,1, 1,0,0});
    add('{0,4'b0010,0,0,ACCESS,32'hDEADBEEF,0, M2C,1,0,32'h200,0,4'hF,4'b1101,0,0,1, 1,0,32'hDEADBEEF});
    add('{0,4'b0010,0,0,BUSY,0,0, M2C,1,0,32'h200,0,4'hF,4'hF,0,0,1, 1,0,0});
    add('{0,4'b0010,0,0,ACCESS,32'hCAFEF00D,0, M2C,1,0,32'h200,0,4'hF,4'b1101,0,0,1, 1,0,32'hCAFEF00D});
    add('{0,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,2, 1,0,0});
    // Dirty hit: core 0 wants exclusive, cores 1 and 3 both hold dirty; core 1 answers.
    add('{0,4'b0001,4'b0010,4'b0011,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,2, 0,0,0});
    add('{0,4'b0001,4'b1010,4'b1011,FREE,0,0, SNOOP,0,0,0,0,4'hF,4'hF,4'b1110,4'b1110,2, 0,0,0});
    add('{0,4'b0001,4'b1010,4'b1011,BUSY,0,0, C2C,0,1,32'h200,32'h11111111,4'hF,4'hF,4'b0010,0,2, 0,0,32'h11111111});
    add('{0,4'b0001,4'b1010,4'b1011,ACCESS,0,0, C2C,0,1,32'h200,32'h11111111,4'hF,4'b1100,4'b0010,0,2, 0,0,32'h11111111});
    add('{0,4'b0001,4'b1010,4'b1011,ACCESS,0,0, C2C,0,1,32'h200,32'h11111111,4'hF,4'b1100,4'b0010,0,2, 0,0,32'h11111111});
    add('{0,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,1, 0,0,0});
    // Writeback abort: dropping dWEN kills the write enable in that same cycle.
    add('{0,0,4'b0001,0,FREE,0,32'h500, IDLE,0,0,0,0,4'hF,4'hF,0,0,1, 0,0,0});
    add('{0,0,4'b0001,0,BUSY,0,32'h500, WB,0,1,32'h500,32'hAAAA0000,4'hF,4'hF,0,0,1, 0,0,0});
    add('{0,0,0,0,ACCESS,0,32'h500, WB,0,0,0,0,4'hF,4'hF,0,0,1, 0,0,0});
    add('{0,0,0,0,FREE,0,0, IDLE,0,0,0,0,4'hF,4'hF,0,0,1, 0,0,0});
    for (int k = 0; k < 4; k++) iaddr[k] = 32'h1000 + 32'(k * 4);
    daddr  = {32'h400, 32'h300, 32'h200, 32'h0};
    dstore = {32'h33333333, 32'h22222222, 32'h11111111, 32'hAAAA0000};
    iREN = 0; dREN = 0; dWEN = 0; ccwrite = 0; ramstate = FREE; ramload = 0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_regs", {dut.state, dut.gptr, dut.req, dut.rsp, dut.wcnt, dut.scnt}, 0);
    chk("rst_waits", {iwait, dwait}, 8'hFF);
    chk("rst_outs", {ramREN, ramWEN, ramaddr, ramstore, ccwait, ccinv}, 0);
    chk("rst_loads", {|iload, |dload, |ccsnoopaddr}, 0);
    step();
    foreach (tv[i]) begin
      drive(tv[i]);
      @(negedge CLK);
      chk($sformatf("vec%0d", i),
          {dut.state, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, ccwait, ccinv, dut.gptr, iload[tv[i].c], dload[tv[i].c]},
          {tv[i].st, tv[i].ren, tv[i].wen, tv[i].addr, tv[i].store, tv[i].iw, tv[i].dw, tv[i].cw, tv[i].inv, tv[i].g, tv[i].il, tv[i].dl});
      step();
    end
    // Timeout: core 3 holds dWEN without ccwrite while core 2 snoops.
    dREN = 4'b0100; dWEN = 4'b1000; ccwrite = 0; ramstate = FREE; daddr[0] = 0;
    @(negedge CLK);
    chk("to_idle", {ccwait, ramREN}, 0);
    step();
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      chk($sformatf("to_snoop%0d", i), {ccwait, ramREN, ccsnoopaddr[0], ccsnoopaddr[2], ccinv}, {4'b1011, 1'b0, 32'h300, 32'h0, 4'b0});
      step();
    end
    @(negedge CLK);
    chk("to_m2c", {ramREN, ramaddr, ccwait}, {1'b1, 32'h300, 4'b0});
    step();
    dREN = 0; dWEN = 0;
    @(negedge CLK);
    chk("to_abort", {ramREN, ramWEN, dwait}, {2'b00, 4'hF});
    step();
    @(negedge CLK);
    chk("to_gptr", {dut.state, dut.gptr}, {IDLE, 2'd3});
    // Reset during the first C2C beat.
    dREN = 4'b0001; dWEN = 4'b0010; ccwrite = 4'b0011;
    step();
    @(negedge CLK);
    chk("rs_snoop", ccwait, 4'b1110);
    step();
    @(negedge CLK);
    chk("rs_c2c", {ramWEN, ramaddr, ramstore}, {1'b1, 32'h200, 32'h11111111});
    ramstate = ACCESS;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rs_after", {dut.state, dut.gptr, ramREN, ramWEN, iwait, dwait, ccwait}, {IDLE, 2'd0, 2'b00, 4'hF, 4'hF, 4'h0});
    dREN = 0; dWEN = 0; ccwrite = 0; ramstate = FREE;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/coherency_bus_ctrl.md
Name: coherency_bus_ctrl

Overview:
- Parametrised N-core snooping coherency controller and memory-bus arbiter.
- Sits between the per-core cache controllers and the single-port RAM.
- Successor to the fixed two-core controller. Adds:
  - NCORES-way round-robin arbitration.
  - Configurable block size, with a per-transfer word counter.
  - Cache-to-cache transfers that also write the block back to RAM.
  - A bounded snoop window.

Parameters:
- NCORES, default 2: number of cores/caches; must be >=2.
- BLK_WORDS, default 2: words per cache block; transfers end after this many RAM ACCESS beats.
- SNOOP_MAX, default 15: maximum cycles in SNOOP before forcing a memory read.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  NCORES  per-core instruction read request.
- iaddr  in  NCORESx32  per-core instruction address.
- dREN  in  NCORES  per-core data read request.
- dWEN  in  NCORES  per-core data write/writeback request.
- daddr  in  NCORESx32  per-core data address.
- dstore  in  NCORESx32  per-core store/writeback data.
- ccwrite  in  NCORES  requestor: read-exclusive intent; snooped core: holds dirty copy.
- iwait  out  NCORES  instruction wait, active-high.
- dwait  out  NCORES  data wait, active-high.
- iload  out  NCORESx32  instruction data to each core.
- dload  out  NCORESx32  data to each core.
- ccwait  out  NCORES  snoop in progress for a core.
- ccinv  out  NCORES  invalidate request to a core.
- ccsnoopaddr  out  NCORESx32  snoop address to each core.
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR, from the shared package.
- ramload  in  32  RAM read data.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.

Behaviour:
- Reset (nRST low at a CLK edge):
  - state=IDLE, grant pointer gptr=0, req=0, rsp=0, wcnt=0, scnt=0.
  - All outputs default: iwait=dwait=all-ones; every other output is 0.
- Output defaults apply in every state unless overridden below.
- IDLE arbitration:
  - A core is eligible if it has any of iREN, dREN or dWEN set.
  - Round-robin search starts at gptr and wraps at NCORES-1 to 0; the first eligible core becomes req.
  - Request type for req, in priority order: dWEN -> WB; dREN -> SNOOP; iREN -> IF.
  - wcnt is cleared on IDLE exit. No outputs change in IDLE; the decision takes one cycle.
- IF state:
  - ramREN=1, ramaddr=iaddr[req], iload[req]=ramload.
  - iwait[req]=0 when ramstate is ACCESS. This is a single-word transfer.
  - Exit to IDLE on ACCESS.
- WB state:
  - ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req].
  - dwait[req]=0 on ACCESS; wcnt increments on each ACCESS.
  - Exit to IDLE on ACCESS when wcnt==BLK_WORDS-1.
- SNOOP state:
  - For every core k!=req: ccwait[k]=1, ccsnoopaddr[k]=daddr[req], ccinv[k]=ccwrite[req].
  - scnt increments each cycle.
  - rsp = first core after req, in rotation order, with dWEN&ccwrite set → C2C.
  - Otherwise, if no core k!=req has dWEN set → M2C.
  - Otherwise, if scnt==SNOOP_MAX → M2C (timeout).
  - Otherwise stay in SNOOP.
- C2C state:
  - ccwait stays asserted for rsp.
  - Data path: dload[req]=dstore[rsp], ramWEN=1, ramaddr=daddr[rsp], ramstore=dstore[rsp] (memory updated in parallel).
  - On ACCESS: dwait[req]=dwait[rsp]=0 and wcnt++.
  - Exit to IDLE after beat BLK_WORDS.
- M2C state:
  - ramREN=1, ramaddr=daddr[req], dload[req]=ramload.
  - On ACCESS: dwait[req]=0 and wcnt++. All other cores' dwait stay 1.
  - Exit to IDLE after beat BLK_WORDS.
- Abort: if req drops the request bit that started the transaction before completion, return to IDLE next cycle with no write enable asserted that cycle.
- Fairness: on every return to IDLE, gptr = (req+1) mod NCORES. This applies to normal completion, abort and timeout.
- ramstate handling:
  - FREE or BUSY: hold state, counters unchanged.
  - ERROR: treated as BUSY.
- Simultaneous events: if multiple snooped cores assert dWEN&ccwrite, only rsp is serviced; the others keep waiting.
- Widths:
  - wcnt is $clog2(BLK_WORDS)+1 bits; scnt is $clog2(SNOOP_MAX+1) bits.
  - gptr and req/rsp indices are $clog2(NCORES) bits and wrap modulo NCORES.
- Reset mid-transaction aborts immediately. The RAM sees ramREN/ramWEN low on the next cycle.

Decomposition:
- Shared package cpu_types_pkg holds ramstate_t (FREE/BUSY/ACCESS/ERROR) and word_t.
- A local enum busstate_t {IDLE, IF, WB, SNOOP, C2C, M2C} lives in the package for bench visibility.
- One sub-module, rr_arbiter (parameter N): inputs req vector and pointer; outputs grant index and valid, purely combinational.

Test Plan:
- Arbitration: NCORES=4, cores 1 and 3 raise iREN, gptr=2, RAM gives ACCESS after 2 BUSY cycles → core 3 served first (iwait[3] low 1 cycle), then core 1; gptr ends at 2.
- Writeback: BLK_WORDS=2, core 0 dWEN with addr 0x100/0x104 → two ramWEN beats, dwait[0] low twice, then IDLE; ccwait never asserted.
- Clean miss: core 1 dREN, ccwrite=0, peers dWEN=0 → SNOOP 1 cycle then M2C; dload[1]=ramload 0xDEADBEEF, 0xCAFEF00D; ccinv all 0.
- Dirty hit: core 0 dREN+ccwrite, core 1 responds with dWEN+ccwrite and dstore 0x11111111 → ccinv[1]=1 in SNOOP, C2C forwards 0x11111111 to dload[0] and ramstore; both dwaits drop on ACCESS.
- Timeout: a peer holds dWEN without ccwrite for 20 cycles, SNOOP_MAX=15 → M2C entered after exactly 15 SNOOP cycles.
- Reset: nRST low mid-C2C beat 1 → next cycle IDLE, ramWEN=0, all waits 1, gptr=0.
